// File: rtl/reg_bank_sb.sv
// -----------------------------------------------------------------------------
// reg_bank_sb
//
// Register file of NUM_REGS x DATA_W with:
//   - one binary-addressed write port (ALU writeback),
//   - two independent combinational read ports with write-through bypass,
//   - a per-register busy scoreboard used by issue logic to detect operands
//     that are still waiting for their producing instruction,
//   - a registered popcount of the busy bits, kept up to date incrementally,
//   - a flattened copy of the whole register file for debug observation.
//
// Ports
//   Clock        in   rising-edge clock for all state
//   Reset_n      in   asynchronous active-low reset (clears regs, busy, count)
//   Wr_En        in   writeback strobe
//   Wr_Addr      in   writeback register index
//   ALU_Result   in   writeback data
//   Rd_Addr_A/B  in   read indices
//   Rd_Data_A/B  out  read data (combinational, bypassed from writeback)
//   Hazard_A/B   out  operand still pending (combinational)
//   Busy_Set     in   issue strobe: mark Busy_Addr pending
//   Busy_Addr    in   register to mark pending
//   Busy_Count   out  registered number of pending registers
//   Regs_Flat    out  register i at bits [i*DATA_W +: DATA_W]
//
// Strobe semantics: Wr_En and Busy_Set are single-cycle qualifiers sampled on
// the rising edge of Clock; there is no backpressure, every strobe presented
// with a valid address is accepted on that edge.
// -----------------------------------------------------------------------------
module reg_bank_sb #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = 4,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic                         Clock,
   input  logic                         Reset_n,
   input  logic                         Wr_En,
   input  logic [ADDR_W-1:0]            Wr_Addr,
   input  logic [DATA_W-1:0]            ALU_Result,
   input  logic [ADDR_W-1:0]            Rd_Addr_A,
   input  logic [ADDR_W-1:0]            Rd_Addr_B,
   output logic [DATA_W-1:0]            Rd_Data_A,
   output logic [DATA_W-1:0]            Rd_Data_B,
   output logic                         Hazard_A,
   output logic                         Hazard_B,
   input  logic                         Busy_Set,
   input  logic [ADDR_W-1:0]            Busy_Addr,
   output logic [ADDR_W:0]              Busy_Count,
   output logic [DATA_W*NUM_REGS-1:0]   Regs_Flat
);

   localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

   // An address takes part in storage only if it is in range and is not the
   // hardwired zero register. Reads of such addresses return 0 without
   // bypass, writes and busy marks to them are dropped.
   function automatic logic addr_live(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < NUM_REGS_L) && !(ZERO_REG && (a == '0));
   endfunction

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [ADDR_W:0]     count_q;
   logic [ADDR_W:0]     count_d;

   logic wr_ok;
   logic set_ok;
   logic busy_at_wr;
   logic busy_at_set;

   assign wr_ok  = Wr_En    && addr_live(Wr_Addr);
   assign set_ok = Busy_Set && addr_live(Busy_Addr);

   // ---------------------------------------------------------------------------
   // Next-state: write clears busy, set marks busy; a set on the same register
   // in the same edge wins because the newer issue supersedes the result.
   // ---------------------------------------------------------------------------
   always_comb begin
      regs_d      = regs_q;
      busy_d      = busy_q;
      busy_at_wr  = 1'b0;
      busy_at_set = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (wr_ok && (Wr_Addr == ADDR_W'(i))) begin
            regs_d[i]  = ALU_Result;
            busy_d[i]  = 1'b0;
            busy_at_wr = busy_q[i];
         end
         if (set_ok && (Busy_Addr == ADDR_W'(i))) begin
            busy_d[i]   = 1'b1;
            busy_at_set = busy_q[i];
         end
      end
   end

   // Incremental popcount: +1 when a clear register becomes busy, -1 when a
   // busy register is cleared and not re-marked on the same edge.
   always_comb begin
      count_d = count_q;
      if (set_ok && !busy_at_set) begin
         count_d = count_d + (ADDR_W+1)'(1);
      end
      if (wr_ok && busy_at_wr && !(set_ok && (Busy_Addr == Wr_Addr))) begin
         count_d = count_d - (ADDR_W+1)'(1);
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         regs_q  <= '{default: '0};
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         regs_q  <= regs_d;
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Read ports. A matching writeback in the current cycle forwards its data
   // and also masks the hazard, since the operand is being produced now.
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] stored_a;
   logic [DATA_W-1:0] stored_b;
   logic              pend_a;
   logic              pend_b;

   always_comb begin
      stored_a = '0;
      stored_b = '0;
      pend_a   = 1'b0;
      pend_b   = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (Rd_Addr_A == ADDR_W'(i)) begin
            stored_a = regs_q[i];
            pend_a   = busy_q[i];
         end
         if (Rd_Addr_B == ADDR_W'(i)) begin
            stored_b = regs_q[i];
            pend_b   = busy_q[i];
         end
      end
   end

   always_comb begin
      Rd_Data_A = '0;
      Hazard_A  = 1'b0;
      if (addr_live(Rd_Addr_A)) begin
         if (Wr_En && (Wr_Addr == Rd_Addr_A)) begin
            Rd_Data_A = ALU_Result;
         end else begin
            Rd_Data_A = stored_a;
            Hazard_A  = pend_a;
         end
      end
   end

   always_comb begin
      Rd_Data_B = '0;
      Hazard_B  = 1'b0;
      if (addr_live(Rd_Addr_B)) begin
         if (Wr_En && (Wr_Addr == Rd_Addr_B)) begin
            Rd_Data_B = ALU_Result;
         end else begin
            Rd_Data_B = stored_b;
            Hazard_B  = pend_b;
         end
      end
   end

   assign Busy_Count = count_q;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign Regs_Flat[g*DATA_W +: DATA_W] = regs_q[g];
   end

endmodule

// File: tb/tb_reg_bank_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_sb
//
// Directed + short random bench for reg_bank_sb configured with NUM_REGS=12,
// ADDR_W=4 and ZERO_REG=1, so out-of-range addresses (12..15) and the
// hardwired zero register are both reachable. Expected values come from
// constants and a small spec-level model (register array + busy bits, count
// taken as a popcount), pushed to exp_q and popped at each comparison.
// -----------------------------------------------------------------------------
module tb_reg_bank_sb;

   localparam int DW = 32;
   localparam int NR = 12;
   localparam int AW = 4;
   localparam int FW = DW * NR;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic Clock;
   logic Reset_n;

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // ---------------------------------------------------------------------------
   // DUT
   // ---------------------------------------------------------------------------
   logic          Wr_En;
   logic [AW-1:0] Wr_Addr;
   logic [DW-1:0] ALU_Result;
   logic [AW-1:0] Rd_Addr_A;
   logic [AW-1:0] Rd_Addr_B;
   logic [DW-1:0] Rd_Data_A;
   logic [DW-1:0] Rd_Data_B;
   logic          Hazard_A;
   logic          Hazard_B;
   logic          Busy_Set;
   logic [AW-1:0] Busy_Addr;
   logic [AW:0]   Busy_Count;
   logic [FW-1:0] Regs_Flat;

   reg_bank_sb #(
      .DATA_W  (DW),
      .NUM_REGS(NR),
      .ADDR_W  (AW),
      .ZERO_REG(1'b1)
   ) dut (
      .Clock     (Clock),
      .Reset_n   (Reset_n),
      .Wr_En     (Wr_En),
      .Wr_Addr   (Wr_Addr),
      .ALU_Result(ALU_Result),
      .Rd_Addr_A (Rd_Addr_A),
      .Rd_Addr_B (Rd_Addr_B),
      .Rd_Data_A (Rd_Data_A),
      .Rd_Data_B (Rd_Data_B),
      .Hazard_A  (Hazard_A),
      .Hazard_B  (Hazard_B),
      .Busy_Set  (Busy_Set),
      .Busy_Addr (Busy_Addr),
      .Busy_Count(Busy_Count),
      .Regs_Flat (Regs_Flat)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [FW-1:0] exp_q[$];
   int n_tests;
   int n_fail;

   task automatic push(input logic [FW-1:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [FW-1:0] obs);
      logic [FW-1:0] exp_v;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s: got %0h, no expected value queued", tag, obs);
         return;
      end
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   logic [DW-1:0] m_regs [NR];
   logic          m_busy [NR];

   function automatic logic m_live(input int a);
      return (a < NR) && (a != 0);
   endfunction

   function automatic logic [DW-1:0] m_rd(input int a);
      if (!m_live(a)) return '0;
      if (Wr_En && (int'(Wr_Addr) == a)) return ALU_Result;
      return m_regs[a];
   endfunction

   function automatic logic m_hz(input int a);
      if (!m_live(a)) return 1'b0;
      if (Wr_En && (int'(Wr_Addr) == a)) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic logic [FW-1:0] m_flat();
      logic [FW-1:0] f;
      f = '0;
      for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_regs[i];
      return f;
   endfunction

   function automatic logic [FW-1:0] m_count();
      logic [FW-1:0] c;
      c = '0;
      for (int i = 0; i < NR; i++) c = c + FW'(m_busy[i]);
      return c;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NR; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   task automatic m_edge();
      int wa;
      int ba;
      wa = int'(Wr_Addr);
      ba = int'(Busy_Addr);
      if (Wr_En && m_live(wa)) begin
         m_regs[wa] = ALU_Result;
         m_busy[wa] = 1'b0;
      end
      if (Busy_Set && m_live(ba)) m_busy[ba] = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic idle();
      Wr_En    = 1'b0;
      Busy_Set = 1'b0;
   endtask

   task automatic drive_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      Wr_En      = 1'b1;
      Wr_Addr    = a;
      ALU_Result = d;
   endtask

   task automatic drive_set(input logic [AW-1:0] a);
      Busy_Set  = 1'b1;
      Busy_Addr = a;
   endtask

   // Advance the model with the current inputs, queue the registered results,
   // clock once and compare just after the edge.
   task automatic edge_and_check(input string tag);
      m_edge();
      push(m_flat());
      push(m_count());
      @(posedge Clock);
      #1;
      check({tag, "_flat"}, Regs_Flat);
      check({tag, "_cnt"}, FW'(Busy_Count));
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      n_tests    = 0;
      n_fail     = 0;
      Reset_n    = 1'b1;
      Wr_En      = 1'b0;
      Wr_Addr    = '0;
      ALU_Result = '0;
      Rd_Addr_A  = '0;
      Rd_Addr_B  = '0;
      Busy_Set   = 1'b0;
      Busy_Addr  = '0;
      m_reset();

      // Power-on reset, checked before any clock edge.
      #1 Reset_n = 1'b0;
      #1;
      Rd_Addr_A = 4'd1;
      #1;
      push('0); check("rst_flat", Regs_Flat);
      push('0); check("rst_cnt", FW'(Busy_Count));
      push('0); check("rst_rd_a", FW'(Rd_Data_A));
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      Reset_n = 1'b1;
      @(posedge Clock);
      #1;

      // Successive writes r1, r2, r3, then a busy mark on r5.
      drive_wr(4'd1, 32'hAAAA_AAAA); edge_and_check("w1");
      drive_wr(4'd2, 32'h0000_0002); edge_and_check("w2");
      drive_wr(4'd3, 32'h0000_000A); edge_and_check("w3");
      push({{(FW-4*DW){1'b0}}, 32'h0000_000A, 32'h0000_0002, 32'hAAAA_AAAA, 32'h0});
      check("w123_const", Regs_Flat);
      idle(); drive_set(4'd5); edge_and_check("bs5");

      // Asynchronous reset between edges.
      idle();
      Reset_n = 1'b0;
      m_reset();
      #1;
      push('0); check("arst_flat", Regs_Flat);
      push('0); check("arst_cnt", FW'(Busy_Count));
      push('0); check("arst_rd_a", FW'(Rd_Data_A));
      #1 Reset_n = 1'b1;
      @(posedge Clock);
      #1;

      // Bypass: same-cycle write to r5 visible on port A, port B sees old r6.
      drive_wr(4'd5, 32'h0000_1111); edge_and_check("pre5");
      drive_wr(4'd6, 32'h0000_6666); edge_and_check("pre6");
      drive_wr(4'd5, 32'h0000_1234);
      Rd_Addr_A = 4'd5;
      Rd_Addr_B = 4'd6;
      #1;
      push(FW'(32'h0000_1234)); check("byp_a", FW'(Rd_Data_A));
      push(FW'(32'h0000_6666)); check("byp_b", FW'(Rd_Data_B));
      edge_and_check("byp");

      // Busy r7: hazard appears after the edge, cleared by writeback.
      idle(); drive_set(4'd7);
      Rd_Addr_A = 4'd7;
      #1;
      push('0); check("hz7_pre", FW'(Hazard_A));
      edge_and_check("bs7");
      idle();
      #1;
      push(FW'(1)); check("hz7", FW'(Hazard_A));
      push(FW'(1)); check("cnt7", FW'(Busy_Count));
      drive_wr(4'd7, 32'h0000_0055);
      #1;
      push('0); check("hz7_wb", FW'(Hazard_A));
      push(FW'(32'h55)); check("rd7_wb", FW'(Rd_Data_A));
      edge_and_check("wb7");
      push('0); check("cnt7_clr", FW'(Busy_Count));

      // r4 already busy, set and write on the same edge: data lands, stays busy.
      idle(); drive_set(4'd4); edge_and_check("bs4");
      drive_set(4'd4); drive_wr(4'd4, 32'h0000_4444); edge_and_check("r4both");
      idle();
      Rd_Addr_A = 4'd4;
      Rd_Addr_B = 4'd4;
      #1;
      push(FW'(32'h4444)); check("rd4_a", FW'(Rd_Data_A));
      push(FW'(32'h4444)); check("rd4_b", FW'(Rd_Data_B));
      push(FW'(1)); check("hz4_a", FW'(Hazard_A));
      push(FW'(1)); check("hz4_b", FW'(Hazard_B));
      push(FW'(1)); check("cnt4", FW'(Busy_Count));

      // r8 not busy, set and write together: count goes up.
      drive_set(4'd8); drive_wr(4'd8, 32'h0000_8888); edge_and_check("r8both");
      idle();
      Rd_Addr_A = 4'd8;
      #1;
      push(FW'(1)); check("hz8", FW'(Hazard_A));
      push(FW'(2)); check("cnt8", FW'(Busy_Count));

      // Hardwired zero register.
      drive_wr(4'd0, 32'hFFFF_FFFF); drive_set(4'd0);
      Rd_Addr_A = 4'd0;
      Rd_Addr_B = 4'd0;
      #1;
      push('0); check("z_rd_a", FW'(Rd_Data_A));
      push('0); check("z_hz_b", FW'(Hazard_B));
      edge_and_check("z");
      idle();
      #1;
      push('0); check("z_rd_after", FW'(Rd_Data_A));
      push(FW'(2)); check("z_cnt", FW'(Busy_Count));

      // Out-of-range addresses and the last valid register.
      drive_wr(4'd13, 32'hDEAD_BEEF); drive_set(4'd13);
      Rd_Addr_B = 4'd13;
      Rd_Addr_A = 4'd12;
      #1;
      push('0); check("oor_rd_b", FW'(Rd_Data_B));
      push('0); check("oor_hz_b", FW'(Hazard_B));
      push('0); check("oor_rd_a12", FW'(Rd_Data_A));
      edge_and_check("oor");
      idle(); drive_wr(4'd11, 32'h0000_0B11);
      Rd_Addr_A = 4'd11;
      #1;
      push(FW'(32'h0B11)); check("rd11_byp", FW'(Rd_Data_A));
      edge_and_check("w11");

      // Random traffic against the model.
      for (int n = 0; n < 60; n++) begin
         Wr_En      = 1'($urandom_range(0, 1));
         Wr_Addr    = AW'($urandom_range(0, 15));
         ALU_Result = $urandom;
         Busy_Set   = 1'($urandom_range(0, 1));
         Busy_Addr  = AW'($urandom_range(0, 15));
         Rd_Addr_A  = AW'($urandom_range(0, 15));
         Rd_Addr_B  = ($urandom_range(0, 3) == 0) ? Wr_Addr : AW'($urandom_range(0, 15));
         #1;
         push(FW'(m_rd(int'(Rd_Addr_A)))); check("rnd_rd_a", FW'(Rd_Data_A));
         push(FW'(m_hz(int'(Rd_Addr_A)))); check("rnd_hz_a", FW'(Hazard_A));
         push(FW'(m_rd(int'(Rd_Addr_B)))); check("rnd_rd_b", FW'(Rd_Data_B));
         push(FW'(m_hz(int'(Rd_Addr_B)))); check("rnd_hz_b", FW'(Hazard_B));
         edge_and_check("rnd");
      end

      idle();
      repeat (2) @(posedge Clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_bank_sb.md
# reg_bank_sb

Parametrised successor to the 16 x 32 one-hot-enable register bank: a register file of NUM_REGS x DATA_W with one binary-addressed write port, two read ports with write-through bypass, and a per-register busy scoreboard for pipelined issue. It sits between the decode/issue stage, which reads operands and marks destination registers busy, and the ALU writeback, which writes ALU_Result. It also exposes the full register contents flattened for debug and bench observation.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 16, number of registers (2..2**ADDR_W)
- ADDR_W, 4, address width
- ZERO_REG, 0, 1 = register 0 is hardwired to zero
- Clock  in  1  single clock; all state updates on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Wr_En  in  1  write strobe
- Wr_Addr  in  ADDR_W  write register index
- ALU_Result  in  DATA_W  write data
- Rd_Addr_A / Rd_Addr_B  in  ADDR_W  read indices
- Rd_Data_A / Rd_Data_B  out  DATA_W  read data (combinational)
- Hazard_A / Hazard_B  out  1  read operand is pending (combinational)
- Busy_Set  in  1  mark Busy_Addr pending (instruction issued)
- Busy_Addr  in  ADDR_W  register to mark busy
- Busy_Count  out  ADDR_W+1  registered count of busy registers
- Regs_Flat  out  DATA_W*NUM_REGS  register i at bits [i*DATA_W +: DATA_W]

## Operation
- Storage: NUM_REGS registers of DATA_W bits, plus busy[NUM_REGS].
- Write: on rising edge with Wr_En=1 and Wr_Addr valid, reg[Wr_Addr] <= ALU_Result and busy[Wr_Addr] <= 0.
- Busy set: on rising edge with Busy_Set=1 and Busy_Addr valid, busy[Busy_Addr] <= 1.
- Same edge, same address, write and Busy_Set both active: data is written; busy ends at 1 (set wins, new issue supersedes the old result).
- Read: Rd_Data_X = ALU_Result when Wr_En=1 and Wr_Addr==Rd_Addr_X (bypass), else reg[Rd_Addr_X].
- Hazard_X = busy[Rd_Addr_X] and not (Wr_En=1 and Wr_Addr==Rd_Addr_X). The bypass clears the hazard in the writeback cycle.
- ZERO_REG=1: writes to address 0 are ignored, Busy_Set to 0 is ignored, a read of 0 returns 0 with no bypass, and Hazard is 0.
- Address valid means < NUM_REGS. An out-of-range write or Busy_Set is a no-op. An out-of-range read returns 0 with Hazard 0.
- Busy_Count is a register that always equals popcount(busy) after each edge. It is maintained incrementally: +1 for a set of a non-busy register, -1 for a clear of a busy register, net 0 when both apply to the same register.
- Both read ports are fully independent and may use the same address.

## Timing
- Reset (Reset_n=0, asynchronous): every reg = 0, every busy = 0, Busy_Count = 0, Regs_Flat = 0 immediately, independent of Clock. Reset deasserts synchronously to the next edge at the bench level.
- Reset asserted mid-operation discards all pending writes and busy marks with no partial update. The first edge after release is a normal cycle.
- Write latency: 0 cycles through the bypass on Rd_Data, 1 edge into storage and Regs_Flat.
- Busy latency: Hazard rises the cycle after the Busy_Set edge and falls combinationally in the writeback cycle.
- Rd_Data, Hazard: combinational from addresses, Wr_En, Wr_Addr, ALU_Result, and state.
- Busy_Count and Regs_Flat change only on Clock edges or reset.

## Test plan
- Reset, then write 0xAAAAAAAA to r1, 0x2 to r2, 0xA to r3 on successive edges -> Regs_Flat shows r1=0xAAAAAAAA, r2=0x2, r3=0xA, all others 0. Assert Reset_n=0 between edges -> all outputs 0 before the next edge.
- Wr_En=1, Wr_Addr=5, ALU_Result=0x1234, Rd_Addr_A=5 in the same cycle -> Rd_Data_A=0x1234 before the edge. Rd_Addr_B=6 -> old r6.
- Busy_Set r7 -> next cycle Hazard_A=1 for Rd_Addr_A=7 and Busy_Count=1. Then write r7=0x55 -> Hazard_A=0 in that cycle, Busy_Count=0 after the edge.
- Busy_Set and Wr_En both on r4 in the same edge, r4 previously busy -> r4=new data, busy[4]=1, Busy_Count unchanged.
- ZERO_REG=1: write 0xFFFFFFFF to r0 and Busy_Set r0 -> Rd_Data=0, Hazard=0, Busy_Count=0.
- NUM_REGS=12, ADDR_W=4: write to address 13 -> no state change. Read 13 -> 0. Busy_Set 13 -> Busy_Count unchanged.
